// File: rtl/boot_loader_dma.sv
// boot_loader_dma: power-on boot sequencer.
//
// Optionally clears VRAM to a fill character, then copies the first L bytes of the
// boot ROM into main RAM at BASE (wrapping modulo 2**ADDR_W), where L = min(len, MAX_LEN).
// The CPU is held in reset until the sequence completes. A start pulse in IDLE or DONE
// (re)starts the sequence; a start while busy is ignored.
//
// Optional feature, macro BOOT_LOADER_VERIFY_EN: after the copy, each byte is read back
// through the main RAM read port and compared against the ROM; any mismatch sets the
// sticky verify_err and keeps cpu_rst_n low.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, len         start pulse and image length (sampled on an accepted start)
//   rom_addr/rom_data  boot ROM byte address / data (data valid one cycle later)
//   ada/din/cea        main RAM write address / data / strobe
//   adb/ceb/dout       main RAM read address / enable / data (verify build only)
//   v_ada/v_din/v_cea  VRAM write address / data / strobe
//   busy, done         sequence in progress / sticky completion flag
//   cpu_rst_n          CPU reset, released once the sequence completes cleanly
//   verify_err         sticky read-back mismatch flag (verify build only)
module boot_loader_dma #(
    parameter int unsigned       ADDR_W     = 15,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       VADDR_W    = 10,
    parameter int unsigned       VRAM_DEPTH = 1024,
    parameter bit                CLEAR_VRAM = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = 8'h20,
    parameter int unsigned       BASE       = 0,
    parameter int unsigned       MAX_LEN    = 4096,
    parameter int unsigned       RD_LAT     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W:0]    len,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [ADDR_W-1:0]  ada,
    output logic [DATA_W-1:0]  din,
    output logic               cea,
    output logic [ADDR_W-1:0]  adb,
    output logic               ceb,
    input  logic [DATA_W-1:0]  dout,
    output logic [VADDR_W-1:0] v_ada,
    output logic [DATA_W-1:0]  v_din,
    output logic               v_cea,
    output logic               busy,
    output logic               done,
    output logic               cpu_rst_n,
    output logic               verify_err
);

    // Shared phase counter: wide enough for VRAM_DEPTH-1 and for L + RD_LAT.
    localparam int unsigned CntW = ((ADDR_W > VADDR_W) ? ADDR_W : VADDR_W) + 2;

    localparam logic [ADDR_W:0]   MaxLen    = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W-1:0] BaseA     = ADDR_W'(BASE);
    localparam logic [CntW-1:0]   DepthLast = CntW'(VRAM_DEPTH - 1);
    localparam logic [CntW-1:0]   RdLatC    = CntW'(RD_LAT);

`ifdef BOOT_LOADER_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StClr, StLoad, StVerify, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StClr, StLoad, StDone} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [CntW-1:0]   len_ext;
    logic              accept;

    assign len_ext = CntW'(len_q);
    assign accept  = start && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    len_d   = (len > MaxLen) ? MaxLen : len;
                    cnt_d   = '0;
                    state_d = CLEAR_VRAM ? StClr : StLoad;
                end
            end
            StClr: begin
                if (cnt_q == DepthLast) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // L+1 cycles: address phase of byte k overlaps write phase of byte k-1.
            StLoad: begin
                if (cnt_q == len_ext) begin
                    cnt_d = '0;
`ifdef BOOT_LOADER_VERIFY_EN
                    state_d = StVerify;
`else
                    state_d = StDone;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef BOOT_LOADER_VERIFY_EN
            // L issue cycles plus RD_LAT+1 cycles to drain the compare pipeline.
            StVerify: begin
                if (cnt_q == len_ext + RdLatC) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rom_addr  = '0;
        ada       = '0;
        din       = '0;
        cea       = 1'b0;
        adb       = '0;
        ceb       = 1'b0;
        v_ada     = '0;
        v_din     = '0;
        v_cea     = 1'b0;
        busy      = (state_q != StIdle) && (state_q != StDone);
        done      = (state_q == StDone);
        cpu_rst_n = (state_q == StDone) && !verify_err;
        unique case (state_q)
            StClr: begin
                v_cea = 1'b1;
                v_ada = cnt_q[VADDR_W-1:0];
                v_din = CLEAR_VAL;
            end
            StLoad: begin
                if (cnt_q < len_ext) begin
                    rom_addr = cnt_q[ADDR_W-1:0];
                end
                if (cnt_q != '0) begin
                    cea = 1'b1;
                    ada = BaseA + cnt_q[ADDR_W-1:0] - ADDR_W'(1);
                    din = rom_data;
                end
            end
`ifdef BOOT_LOADER_VERIFY_EN
            StVerify: begin
                if (cnt_q < len_ext) begin
                    ceb      = 1'b1;
                    adb      = BaseA + cnt_q[ADDR_W-1:0];
                    rom_addr = cnt_q[ADDR_W-1:0];
                end
            end
`endif
            default: ;
        endcase
    end

`ifdef BOOT_LOADER_VERIFY_EN
    // Byte issued in cycle k: ROM byte arrives in k+1, RAM byte in k+RD_LAT. Both are
    // registered and compared together in cycle k+RD_LAT+1.
    logic [RD_LAT:0]   iss_q;
    logic [DATA_W-1:0] rom_pipe_q [RD_LAT];
    logic [DATA_W-1:0] dout_q;
    logic              verr_q;
    logic              issue;

    assign issue = (state_q == StVerify) && (cnt_q < len_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q  <= '0;
            dout_q <= '0;
            verr_q <= 1'b0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                rom_pipe_q[i] <= '0;
            end
        end else begin
            iss_q         <= {iss_q[RD_LAT-1:0], issue};
            dout_q        <= dout;
            rom_pipe_q[0] <= rom_data;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                rom_pipe_q[i] <= rom_pipe_q[i-1];
            end
            if (accept) begin
                verr_q <= 1'b0;
            end else if (iss_q[RD_LAT] && (dout_q != rom_pipe_q[RD_LAT-1])) begin
                verr_q <= 1'b1;
            end
        end
    end

    assign verify_err = verr_q;
`else
    logic unused_ok;
    assign unused_ok  = ^{dout, RdLatC, accept};
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader_dma.sv
// Bench for boot_loader_dma: two instances (default parameters, and BASE=7FFE with no
// VRAM clear and MAX_LEN=64). Expected writes are derived from the sequencing rules
// (clear phase, then one byte per cycle, start at cycle s) and compared to the
// strobes captured on the falling edge. Honours BOOT_LOADER_VERIFY_EN when defined.
`timescale 1ns/1ps
module tb_boot_loader_dma;

    localparam int BASE_B   = 'h7FFE;
    localparam int MAXLEN_A = 4096;
    localparam int MAXLEN_B = 64;
    localparam int DEPTH_A  = 1024;
    localparam int RDL      = 2;
`ifdef BOOT_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a = 0, start_b = 0;
    logic [15:0] len_a = 0, len_b = 0;
    logic [14:0] rom_addr_a, rom_addr_b, ada_a, ada_b, adb_a, adb_b;
    logic [7:0]  rom_data_a = 0, rom_data_b = 0, din_a, din_b, dout_a = 0, dout_b = 0;
    logic [7:0]  v_din_a, v_din_b;
    logic [9:0]  v_ada_a, v_ada_b;
    logic        cea_a, cea_b, ceb_a, ceb_b, v_cea_a, v_cea_b;
    logic        busy_a, busy_b, done_a, done_b, cpu_rst_n_a, cpu_rst_n_b;
    logic        verify_err_a, verify_err_b;

    boot_loader_dma dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .len(len_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .ada(ada_a), .din(din_a), .cea(cea_a),
        .adb(adb_a), .ceb(ceb_a), .dout(dout_a),
        .v_ada(v_ada_a), .v_din(v_din_a), .v_cea(v_cea_a),
        .busy(busy_a), .done(done_a), .cpu_rst_n(cpu_rst_n_a), .verify_err(verify_err_a)
    );

    boot_loader_dma #(
        .VRAM_DEPTH(4), .CLEAR_VRAM(1'b0), .BASE(BASE_B), .MAX_LEN(MAXLEN_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .ada(ada_b), .din(din_b), .cea(cea_b),
        .adb(adb_b), .ceb(ceb_b), .dout(dout_b),
        .v_ada(v_ada_b), .v_din(v_din_b), .v_cea(v_cea_b),
        .busy(busy_b), .done(done_b), .cpu_rst_n(cpu_rst_n_b), .verify_err(verify_err_b)
    );

    function automatic logic [7:0] rom_fn(input int a);
        logic [31:0] t;
        t = a * 37 + (a >> 4) + 5;
        return t[7:0] ^ 8'h5A;
    endfunction

    // Registered ROMs (one-cycle latency).
    always @(posedge clk) begin
        rom_data_a <= rom_fn(int'(rom_addr_a));
        rom_data_b <= rom_fn(int'(rom_addr_b));
    end

    // Main RAMs with two-cycle read latency; optional corruption of byte BASE+2.
    logic [7:0]  mem_a [0:32767];
    logic [7:0]  mem_b [0:32767];
    logic [14:0] ra_a = 0, ra_b = 0;
    bit          corrupt_a = 0, corrupt_b = 0;
    always @(posedge clk) begin
        if (cea_a) mem_a[ada_a] <= din_a;
        if (cea_b) mem_b[ada_b] <= din_b;
        ra_a   <= adb_a;
        ra_b   <= adb_b;
        dout_a <= mem_a[ra_a] ^ ((corrupt_a && ra_a == 15'd2) ? 8'h01 : 8'h00);
        dout_b <= mem_b[ra_b] ^ ((corrupt_b && ra_b == 15'd0) ? 8'h01 : 8'h00);
    end

    typedef struct {int inst; int cyc; int addr; int data;} ev_t;
    ev_t wq[$];
    ev_t vq[$];
    int  overlap = 0;
    int  cfg_bad = 0;

    always @(negedge clk) begin
        if (cea_a)   wq.push_back(ev_t'{0, cyc, int'(ada_a), int'(din_a)});
        if (cea_b)   wq.push_back(ev_t'{1, cyc, int'(ada_b), int'(din_b)});
        if (v_cea_a) vq.push_back(ev_t'{0, cyc, int'(v_ada_a), int'(v_din_a)});
        if (v_cea_b) vq.push_back(ev_t'{1, cyc, int'(v_ada_b), int'(v_din_b)});
        if ((cea_a && v_cea_a) || (cea_b && v_cea_b)) overlap++;
        if (!VER && (ceb_a || ceb_b || adb_a != 0 || adb_b != 0 || verify_err_a || verify_err_b))
            cfg_bad++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // {busy, done, cpu_rst_n, verify_err}
    function automatic logic [3:0] st(input int inst);
        return inst != 0 ? {busy_b, done_b, cpu_rst_n_b, verify_err_b}
                         : {busy_a, done_a, cpu_rst_n_a, verify_err_a};
    endfunction

    task automatic drive(input int inst, input logic s, input int l);
        if (inst == 0) begin
            start_a = s;
            len_a   = 16'(l);
        end else begin
            start_b = s;
            len_b   = 16'(l);
        end
    endtask

    // One full sequence. exp_delay is from the start cycle to the first DONE cycle
    // without the verify phase; the verify phase adds L + RD_LAT + 1 cycles.
    task automatic run_seq(input string tag, input int inst, input int len, input int exp_l,
                           input int exp_delay, input int mid);
        int s, t_done, d, base, n_w, n_v, bad_w, bad_v, delay;
        bit corr;
        logic [3:0] cur;
        d     = inst != 0 ? 0 : DEPTH_A;
        base  = inst != 0 ? BASE_B : 0;
        corr  = VER && (inst != 0 ? corrupt_b : corrupt_a);
        delay = exp_delay + (VER ? exp_l + RDL + 1 : 0);
        @(negedge clk);
        wq.delete();
        vq.delete();
        s = cyc;
        drive(inst, 1'b1, len);
        @(negedge clk);
        drive(inst, 1'b0, 0);
        cur = st(inst);
        chk({tag, "_busy_after_start"}, int'(cur[3]), 1);
        chk({tag, "_done_low_after_start"}, int'(cur[2]), 0);
        t_done = -1;
        for (int i = 0; i < 20000 && t_done < 0; i++) begin
            if (mid > 0 && cyc == s + mid) drive(inst, 1'b1, 3);
            else drive(inst, 1'b0, 0);
            cur = st(inst);
            if (cur[2]) t_done = cyc;
            else @(negedge clk);
        end
        drive(inst, 1'b0, 0);
        chk({tag, "_done_cycle"}, t_done < 0 ? -1 : t_done - s, delay);
        cur = st(inst);
        chk({tag, "_busy_at_done"}, int'(cur[3]), 0);
        chk({tag, "_cpu_rst_n"}, int'(cur[1]), corr ? 0 : 1);
        chk({tag, "_verify_err"}, int'(cur[0]), corr ? 1 : 0);
        n_w = 0; bad_w = 0; n_v = 0; bad_v = 0;
        foreach (wq[j]) if (wq[j].inst == inst) begin
            if (wq[j].cyc != s + 2 + d + n_w || wq[j].addr != ((base + n_w) & 'h7FFF) ||
                wq[j].data != int'(rom_fn(n_w))) bad_w++;
            n_w++;
        end
        foreach (vq[j]) if (vq[j].inst == inst) begin
            if (vq[j].cyc != s + 1 + n_v || vq[j].addr != n_v || vq[j].data != 'h20) bad_v++;
            n_v++;
        end
        chk({tag, "_cea_count"}, n_w, exp_l);
        chk({tag, "_cea_content"}, bad_w, 0);
        chk({tag, "_vcea_count"}, n_v, d);
        chk({tag, "_vcea_content"}, bad_v, 0);
        repeat (3) @(negedge clk);
        cur = st(inst);
        chk({tag, "_done_holds"}, int'(cur[2]), 1);
        chk({tag, "_no_writes_after_done"}, wq.size() + vq.size(), n_w + n_v);
    endtask

    typedef struct {int inst; int len; int exp_l; int exp_delay; int mid;} vec_t;
    vec_t vecs[8];

    initial begin
        logic [3:0] cur;
        int l, el;
        vecs[0] = '{0, 4,    4,    1030, 0};    // clear + 4 bytes
        vecs[1] = '{1, 4,    4,    6,    0};    // BASE=7FFE wraps to 0000, 0001
        vecs[2] = '{1, 0,    0,    2,    0};    // empty image, no clear
        vecs[3] = '{0, 8000, 4096, 5122, 2000}; // clamp; start mid-LOAD ignored
        vecs[4] = '{1, 100,  64,   66,   0};
        vecs[5] = '{1, 64,   64,   66,   0};
        vecs[6] = '{0, 0,    0,    1026, 0};
        vecs[7] = '{1, 1,    1,    3,    0};

        #1;
        cur = st(0);
        chk("reset_status_a", int'(cur), 0);
        cur = st(1);
        chk("reset_status_b", int'(cur), 0);
        chk("reset_strobes", int'({cea_a, v_cea_a, cea_b, v_cea_b}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_status_a", int'(st(0)), 0);

        for (int i = 0; i < 8; i++)
            run_seq($sformatf("vec%0d", i), vecs[i].inst, vecs[i].len, vecs[i].exp_l,
                    vecs[i].exp_delay, vecs[i].mid);

        for (int i = 0; i < 8; i++) begin
            int inst;
            inst = (i < 6) ? 1 : 0;
            l  = (inst != 0) ? int'($urandom_range(0, 150)) : int'($urandom_range(0, 40));
            el = (inst != 0) ? (l > MAXLEN_B ? MAXLEN_B : l) : (l > MAXLEN_A ? MAXLEN_A : l);
            run_seq($sformatf("rnd%0d_len%0d", i, l), inst, l, el,
                    1 + (inst != 0 ? 0 : DEPTH_A) + el + 1, 0);
        end

        // Reset in the middle of the clear phase.
        @(negedge clk);
        drive(0, 1'b1, 4);
        @(negedge clk);
        drive(0, 1'b0, 0);
        repeat (50) @(negedge clk);
        chk("midclr_vcea_high", int'(v_cea_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midclr_strobes_drop", int'({cea_a, v_cea_a}), 0);
        chk("midclr_status", int'(st(0)), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("after_reset", 0, 4, 4, 1030, 0);

`ifdef BOOT_LOADER_VERIFY_EN
        corrupt_a = 1;
        run_seq("verify_corrupt_a", 0, 4, 4, 1030, 0);
        corrupt_a = 0;
        run_seq("verify_clean_a", 0, 4, 4, 1030, 0);
        corrupt_b = 1;
        run_seq("verify_corrupt_b", 1, 4, 4, 6, 0);
        corrupt_b = 0;
`endif

        chk("strobe_overlap", overlap, 0);
        chk("verify_ports_idle", cfg_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader_dma.md
Name: boot_loader_dma

Overview:
- Power-on/boot sequencer between the ROM-held boot image, the main BSRAM (15-bit address, 8-bit data) and the VRAM (10-bit address, 8-bit data).
- Optionally clears VRAM to a fill character, then streams N bytes of the boot image into main RAM at a base address. Holds the CPU in reset until the sequence completes.
- Parametrised successor to the fixed inline boot_program hand-off: generalised widths, depth, base, length and fill, with a restartable sequence.

Parameters:
- ADDR_W, 15, main RAM address width
- DATA_W, 8, data width of RAM, VRAM and ROM
- VADDR_W, 10, VRAM address width
- VRAM_DEPTH, 1024, number of VRAM locations cleared (≤ 2**VADDR_W)
- CLEAR_VRAM, 1, 1 = run the VRAM clear phase, 0 = skip it
- CLEAR_VAL, 8'h20, fill value written to VRAM
- BASE, 0, main RAM destination of image byte 0
- MAX_LEN, 4096, upper clamp on image length
- RD_LAT, 2, main RAM read latency in cycles (verify only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a sequence when idle
- len  in  ADDR_W+1  image length in bytes, sampled on accepted start
- rom_addr  out  ADDR_W  boot ROM byte address
- rom_data  in  DATA_W  ROM byte, valid 1 cycle after rom_addr
- ada  out  ADDR_W  main RAM write address
- din  out  DATA_W  main RAM write data
- cea  out  1  main RAM write strobe, one byte per high cycle
- adb  out  ADDR_W  main RAM read address (verify)
- ceb  out  1  main RAM read enable (verify)
- dout  in  DATA_W  main RAM read data
- v_ada  out  VADDR_W  VRAM write address
- v_din  out  DATA_W  VRAM write data
- v_cea  out  1  VRAM write strobe
- busy  out  1  sequence in progress
- done  out  1  sticky completion flag
- cpu_rst_n  out  1  CPU reset, low until done
- verify_err  out  1  sticky mismatch flag (verify build only)

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0 except cpu_rst_n=0. Reset mid-sequence aborts immediately; no partial-completion indication.
- States: IDLE -> CLR -> LOAD -> [VERIFY] -> DONE.
- IDLE:
  - start=1: latch L = min(len, MAX_LEN); busy=1 from the next cycle.
  - Next state is CLR if CLEAR_VRAM=1, otherwise LOAD.
- CLR:
  - Counter c = 0..VRAM_DEPTH-1, one write per cycle: v_cea=1, v_ada=c, v_din=CLEAR_VAL.
  - Exactly VRAM_DEPTH cycles, then LOAD.
- LOAD (pipelined, 1 byte/cycle):
  - Cycle k (k<L): rom_addr=k.
  - Cycle k+1: cea=1, ada=(BASE+k) mod 2**ADDR_W, din=rom_data.
  - Phase lasts L+1 cycles. L=0: one cycle, no cea pulse.
- DONE: busy=0, done=1, cpu_rst_n=1. Outputs hold until reset or the next start.
- start in DONE restarts: done=0 and cpu_rst_n=0 on the following cycle, new sequence begins.
- start while busy is ignored.
- Strobes are single-cycle and never overlap across phases; cea and v_cea are never high in the same cycle.

Optional Feature:
- Macro: BOOT_LOADER_VERIFY_EN.
- Defined:
  - After LOAD, enter VERIFY. For each k<L: drive ceb=1, adb=BASE+k, rom_addr=k for one cycle.
  - Wait RD_LAT cycles, then compare dout with the registered rom_data.
  - On mismatch, set verify_err=1 (sticky until next start or reset). Continue through all bytes.
  - Then enter DONE. cpu_rst_n rises only if verify_err=0; otherwise it stays low while done=1.
- Undefined: no VERIFY state; ceb=0, adb=0 and verify_err=0 constantly.

Test Plan:
- Reset release, start with len=4, CLEAR_VRAM=1, VRAM_DEPTH=1024 -> exactly 1024 v_cea pulses with v_din=8'h20 at v_ada 0..1023, then 4 cea pulses at ada 0..3 with ROM bytes; done=1 and cpu_rst_n=1 at cycle 1+1024+5.
- BASE=15'h7FFE, len=4 -> writes land at ada 7FFE, 7FFF, 0000, 0001 (wrap).
- len=0, CLEAR_VRAM=0 -> no cea or v_cea pulses; done=1 two cycles after start.
- len=8000 with MAX_LEN=4096 -> exactly 4096 cea pulses. A second start issued mid-LOAD is ignored.
- rst_n asserted mid-CLR -> all strobes drop the same cycle, cpu_rst_n=0, done=0. A later start reruns the full sequence from v_ada=0.
- BOOT_LOADER_VERIFY_EN build, RAM model corrupts address BASE+2 -> verify_err=1, done=1, cpu_rst_n stays 0. Clean RAM model -> verify_err=0, cpu_rst_n=1.
